// File: rtl/mem_stage_lsu_pkg.sv
// Shared constants and helpers for the load/store memory-access stage:
// opcodes, funct3 encodings, FSM states and access-size decoding.
package rv_lsu_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RSP,
    ST_DRAIN
  } lsu_state_e;

  // Byte-lane mask for an access of 2**size bytes, before shifting by offset.
  function automatic logic [7:0] size_mask(input logic [1:0] size);
    case (size)
      2'd0:    return 8'h01;
      2'd1:    return 8'h03;
      2'd2:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] off, input logic [1:0] size);
    logic [3:0] lim;
    lim = (4'd1 << size) - 4'd1;
    return |({1'b0, off} & lim);
  endfunction

  function automatic logic legal_f3(input logic is_load, input logic [2:0] f3,
                                    input logic is64);
    if (is_load) begin
      case (f3)
        F3_B, F3_H, F3_W, F3_BU, F3_HU: return 1'b1;
        F3_D, F3_WU:                    return is64;
        default:                        return 1'b0;
      endcase
    end else begin
      case (f3)
        F3_B, F3_H, F3_W: return 1'b1;
        F3_D:             return is64;
        default:          return 1'b0;
      endcase
    end
  endfunction

  function automatic logic writes_rd(input logic [6:0] opc);
    case (opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_OP, OPC_OP_IMM: return 1'b1;
      default:                                                   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Combinational byte-lane steering: store byte enables and lane replication,
// load-data extraction with sign/zero extension.
module lsu_align
  import rv_lsu_pkg::*;
#(
  parameter  int XLEN  = 32,
  localparam int NB    = XLEN / 8,
  localparam int OFF_W = $clog2(NB)
) (
  input  logic [2:0]       funct3,
  input  logic [OFF_W-1:0] offset,
  input  logic [XLEN-1:0]  rs2,
  input  logic [XLEN-1:0]  rdata,
  output logic [NB-1:0]    be,
  output logic [XLEN-1:0]  wdata,
  output logic [XLEN-1:0]  load_data
);

  logic [15:0]     be_wide;
  logic [XLEN-1:0] rd_sh;

  always_comb begin
    be_wide = {8'h00, size_mask(funct3[1:0])} << offset;
    be      = be_wide[NB-1:0];
  end

  // Each lane takes the rs2 byte at its position modulo the access size.
  always_comb begin
    int src;
    src   = 0;
    wdata = '0;
    for (int i = 0; i < NB; i++) begin
      src = i % (1 << funct3[1:0]);
      wdata[8*i +: 8] = rs2[8*src +: 8];
    end
  end

  always_comb begin
    rd_sh = rdata >> {offset, 3'b000};
    case (funct3)
      F3_B:    load_data = XLEN'($signed(rd_sh[7:0]));
      F3_H:    load_data = XLEN'($signed(rd_sh[15:0]));
      F3_W:    load_data = XLEN'($signed(rd_sh[31:0]));
      F3_BU:   load_data = XLEN'(rd_sh[7:0]);
      F3_HU:   load_data = XLEN'(rd_sh[15:0]);
      F3_WU:   load_data = XLEN'(rd_sh[31:0]);
      default: load_data = rd_sh;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// Load/store memory-access stage between execute and writeback: drives a
// req/gnt/rvalid data port, handles alignment, extension, misalign and flush.
module mem_stage_lsu
  import rv_lsu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 ex_valid,
  output logic                 ex_ready,
  input  logic [ADDR_W-1:0]    ex_pc,
  input  logic [31:0]          ex_ir,
  input  logic [XLEN-1:0]      ex_alu_out,
  input  logic [XLEN-1:0]      ex_rs2,
  output logic                 wb_valid,
  input  logic                 wb_ready,
  output logic [ADDR_W-1:0]    wb_pc,
  output logic [31:0]          wb_ir,
  output logic [XLEN-1:0]      wb_result,
  output logic [4:0]           wb_rd,
  output logic                 wb_we,
  output logic                 wb_exc,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic [ADDR_W-1:0]    dmem_addr,
  output logic [XLEN/8-1:0]    dmem_be,
  output logic [XLEN-1:0]      dmem_wdata,
  input  logic                 dmem_gnt,
  input  logic                 dmem_rvalid,
  input  logic [XLEN-1:0]      dmem_rdata
);

  localparam int   NB    = XLEN / 8;
  localparam int   OFF_W = $clog2(NB);
  localparam logic IS64  = (XLEN == 64);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(NB - 1);

  lsu_state_e state, state_nxt;
  logic       req_c;

  logic [6:0] ex_opc;
  logic [2:0] ex_f3;
  logic       ex_is_load, ex_is_store, ex_is_mem, ex_bad;
  logic       accept, accept_mem, accept_direct;

  logic [ADDR_W-1:0] pc_p1;
  logic [31:0]       ir_p1;
  logic [XLEN-1:0]   addr_p1, rs2_p1;
  logic              load_p1;

  logic [NB-1:0]     be_a;
  logic [XLEN-1:0]   wdata_a, load_a;
  logic              gnt_store, rsp_done;

  // Stage 0: decode the incoming op and decide its path
  assign ex_opc      = ex_ir[6:0];
  assign ex_f3       = ex_ir[14:12];
  assign ex_is_load  = (ex_opc == OPC_LOAD);
  assign ex_is_store = (ex_opc == OPC_STORE);
  assign ex_is_mem   = ex_is_load || ex_is_store;
  assign ex_bad      = ex_is_mem &&
                       (!legal_f3(ex_is_load, ex_f3, IS64) ||
                        misaligned(3'(ex_alu_out[OFF_W-1:0]), ex_f3[1:0]));

  assign ex_ready      = (state == ST_IDLE) && (!wb_valid || wb_ready) && !flush;
  assign accept        = ex_valid && ex_ready;
  assign accept_mem    = accept && ex_is_mem && !ex_bad;
  assign accept_direct = accept && !accept_mem;

  // Stage 1: op held for the duration of the memory transaction
  always_ff @(posedge clk) begin
    if (accept_mem) begin
      pc_p1   <= ex_pc;
      ir_p1   <= ex_ir;
      addr_p1 <= ex_alu_out;
      rs2_p1  <= ex_rs2;
    end
  end

  assign load_p1 = (ir_p1[6:0] == OPC_LOAD);

  lsu_align #(.XLEN(XLEN)) u_align (
    .funct3    (ir_p1[14:12]),
    .offset    (addr_p1[OFF_W-1:0]),
    .rs2       (rs2_p1),
    .rdata     (dmem_rdata),
    .be        (be_a),
    .wdata     (wdata_a),
    .load_data (load_a)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // A grant in the flush cycle still counts: the request was already visible.
  always_comb begin
    state_nxt = state;
    req_c     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept_mem) state_nxt = ST_REQ;
      end
      ST_REQ: begin
        req_c = 1'b1;
        if (dmem_gnt) begin
          if (load_p1) state_nxt = flush ? ST_DRAIN : ST_RSP;
          else         state_nxt = ST_IDLE;
        end else if (flush) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_RSP: begin
        if (dmem_rvalid) state_nxt = ST_IDLE;
        else if (flush)  state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (dmem_rvalid) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign dmem_req   = req_c;
  assign dmem_we    = req_c && !load_p1;
  assign dmem_addr  = req_c ? (ADDR_W'(addr_p1) & ALIGN_MASK) : '0;
  assign dmem_be    = req_c ? be_a : '0;
  assign dmem_wdata = req_c ? wdata_a : '0;

  assign gnt_store = (state == ST_REQ) && dmem_gnt && !load_p1;
  assign rsp_done  = (state == ST_RSP) && dmem_rvalid;

  // Stage 2: writeback record, held while the consumer stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid  <= 1'b0;
      wb_pc     <= '0;
      wb_ir     <= '0;
      wb_result <= '0;
      wb_rd     <= '0;
      wb_we     <= 1'b0;
      wb_exc    <= 1'b0;
    end else if (flush) begin
      wb_valid <= 1'b0;
    end else if (accept_direct) begin
      wb_valid  <= 1'b1;
      wb_pc     <= ex_pc;
      wb_ir     <= ex_ir;
      wb_result <= ex_alu_out;
      wb_rd     <= ex_ir[11:7];
      wb_we     <= !ex_is_mem && writes_rd(ex_opc) && (ex_ir[11:7] != 5'd0);
      wb_exc    <= ex_is_mem;
    end else if (gnt_store || rsp_done) begin
      wb_valid  <= 1'b1;
      wb_pc     <= pc_p1;
      wb_ir     <= ir_p1;
      wb_result <= rsp_done ? load_a : addr_p1;
      wb_rd     <= ir_p1[11:7];
      wb_we     <= rsp_done && (ir_p1[11:7] != 5'd0);
      wb_exc    <= 1'b0;
    end else if (wb_ready) begin
      wb_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: directed ops push expected writeback and
// memory-request records; monitors pop and compare when the DUT presents them.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_pc, ex_ir, ex_alu_out, ex_rs2;
  logic        wb_valid, wb_ready;
  logic [31:0] wb_pc, wb_ir, wb_result;
  logic [4:0]  wb_rd;
  logic        wb_we, wb_exc;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;

  mem_stage_lsu #(.XLEN(32), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc), .ex_ir(ex_ir),
    .ex_alu_out(ex_alu_out), .ex_rs2(ex_rs2),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_pc(wb_pc), .wb_ir(wb_ir),
    .wb_result(wb_result), .wb_rd(wb_rd), .wb_we(wb_we), .wb_exc(wb_exc),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc, ir, res;
    logic [4:0]  rd;
    logic        we, exc, chk_res;
    int          cyc;
  } wb_exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        chk_wd;
  } mem_exp_t;

  wb_exp_t  wb_q[$];
  mem_exp_t mem_q[$];
  wb_exp_t  wb_e;
  mem_exp_t mem_e;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  int          gnt_wait = 0;
  int          rv_delay = 0;
  logic [31:0] rdata_cfg = '0;
  int          wait_cnt = 0;
  int          rsp_cnt  = 0;
  logic        rsp_pend = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory responder: grants after gnt_wait stall cycles, rvalid rv_delay cycles after the earliest slot.
  initial begin
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
      if (rsp_pend) begin
        if (rsp_cnt == 0) begin
          dmem_rvalid = 1'b1; dmem_rdata = rdata_cfg; rsp_pend = 1'b0;
        end else rsp_cnt--;
      end
      if (rst) begin
        wait_cnt = 0; rsp_pend = 1'b0;
      end else if (dmem_req) begin
        if (wait_cnt < gnt_wait) wait_cnt++;
        else begin
          dmem_gnt = 1'b1; wait_cnt = 0;
          if (!dmem_we) begin rsp_pend = 1'b1; rsp_cnt = rv_delay; end
        end
      end else wait_cnt = 0;
    end
  end

  // Writeback monitor
  always @(negedge clk) begin
    if (!rst && wb_valid && wb_ready) begin
      if (wb_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL wb_unexpected: got record pc=%0h ir=%0h required none", wb_pc, wb_ir);
      end else begin
        wb_e = wb_q.pop_front();
        chk("wb_pc", wb_pc, wb_e.pc);
        chk("wb_ir", wb_ir, wb_e.ir);
        chk("wb_rd", wb_rd, wb_e.rd);
        chk("wb_we", wb_we, wb_e.we);
        chk("wb_exc", wb_exc, wb_e.exc);
        if (wb_e.chk_res) chk("wb_result", wb_result, wb_e.res);
        if (wb_e.cyc >= 0) chk("wb_latency_cycle", cyc, wb_e.cyc);
      end
    end
  end

  // Memory-request monitor
  always @(negedge clk) begin
    if (!rst && dmem_req) begin
      if (mem_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL dmem_unexpected: got req addr=%0h required none", dmem_addr);
      end else if (dmem_gnt) begin
        mem_e = mem_q.pop_front();
        chk("dmem_we", dmem_we, mem_e.we);
        chk("dmem_addr", dmem_addr, mem_e.addr);
        chk("dmem_be", dmem_be, mem_e.be);
        if (mem_e.chk_wd) chk("dmem_wdata", dmem_wdata, mem_e.wdata);
      end
    end
  end

  // Called at #1 after a rising edge; returns #1 after the accepting edge.
  task automatic issue(input logic [31:0] pc, ir, alu, rs2, output int acc);
    ex_valid = 1'b1; ex_pc = pc; ex_ir = ir; ex_alu_out = alu; ex_rs2 = rs2;
    acc = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (ex_ready) begin
        @(posedge clk); #1;
        acc = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    ex_valid = 1'b0;
    if (acc < 0) begin
      n_tests++; n_fail++;
      $display("FAIL issue_timeout: got ex_ready=0 for 100 cycles required 1");
    end
  endtask

  task automatic run_op(input logic [31:0] pc, ir, alu, rs2,
                        input logic exp_wb, input logic [31:0] res, input logic chk_res,
                        input logic we, exc, input int lat,
                        input logic exp_mem, input logic mwe, input logic [31:0] maddr,
                        input logic [3:0] mbe, input logic [31:0] mwd);
    int acc;
    wb_exp_t  w;
    mem_exp_t m;
    if (exp_mem) begin
      m.we = mwe; m.addr = maddr; m.be = mbe; m.wdata = mwd; m.chk_wd = mwe;
      mem_q.push_back(m);
    end
    issue(pc, ir, alu, rs2, acc);
    if (exp_wb) begin
      w.pc = pc; w.ir = ir; w.res = res; w.rd = ir[11:7];
      w.we = we; w.exc = exc; w.chk_res = chk_res;
      w.cyc = (lat > 0) ? acc + lat - 1 : -1;
      wb_q.push_back(w);
    end
  endtask

  task automatic wait_idle();
    logic done;
    done = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (wb_q.size() == 0 && mem_q.size() == 0 && ex_ready && !rsp_pend) begin
        done = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL idle_timeout: got wb_q=%0d mem_q=%0d required 0", wb_q.size(), mem_q.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by 500us required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    rst = 1'b1; flush = 1'b0; ex_valid = 1'b0; wb_ready = 1'b1;
    ex_pc = '0; ex_ir = '0; ex_alu_out = '0; ex_rs2 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_we", wb_we, 0);
    chk("rst_wb_exc", wb_exc, 0);
    chk("rst_wb_result", wb_result, 0);
    chk("rst_dmem_req", dmem_req, 0);
    chk("rst_dmem_we", dmem_we, 0);
    chk("rst_dmem_addr", dmem_addr, 0);
    chk("rst_dmem_be", dmem_be, 0);
    chk("rst_dmem_wdata", dmem_wdata, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // ADDI x5 pass-through, latency 1
    run_op(32'h1000, 32'h0000_0293, 32'h1234, 0, 1, 32'h1234, 1, 1, 0, 1, 0, 0, 0, 0, 0);
    wait_idle();
    // LB x6 @0x103, two wait states before grant
    gnt_wait = 2; rv_delay = 0; rdata_cfg = 32'h80FF_FFFF;
    run_op(32'h1004, 32'h0000_0303, 32'h103, 0, 1, 32'hFFFF_FF80, 1, 1, 0, 5, 1, 0, 32'h100, 4'h8, 0);
    wait_idle();
    // LBU x7 @0x103, no wait
    gnt_wait = 0;
    run_op(32'h1008, 32'h0000_4383, 32'h103, 0, 1, 32'h0000_0080, 1, 1, 0, 3, 1, 0, 32'h100, 4'h8, 0);
    wait_idle();
    // SH @0x102
    run_op(32'h100C, 32'h0000_1023, 32'h102, 32'hABCD_1234, 1, 0, 0, 0, 0, 2, 1, 1, 32'h100, 4'hC, 32'h1234_1234);
    wait_idle();
    // LW @0x102: misaligned, no request
    run_op(32'h1010, 32'h0000_2403, 32'h102, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    wait_idle();
    // LH x9 / LHU x10 @0x102, one grant wait and one rvalid delay
    gnt_wait = 1; rv_delay = 1; rdata_cfg = 32'h8001_0000;
    run_op(32'h1014, 32'h0000_1483, 32'h102, 0, 1, 32'hFFFF_8001, 1, 1, 0, 5, 1, 0, 32'h100, 4'hC, 0);
    wait_idle();
    run_op(32'h1018, 32'h0000_5503, 32'h102, 0, 1, 32'h0000_8001, 1, 1, 0, 5, 1, 0, 32'h100, 4'hC, 0);
    wait_idle();
    // SB @0x101 and SW @0x104
    gnt_wait = 0; rv_delay = 0;
    run_op(32'h101C, 32'h0000_0023, 32'h101, 32'h0000_00A5, 1, 0, 0, 0, 0, 2, 1, 1, 32'h100, 4'h2, 32'hA5A5_A5A5);
    wait_idle();
    run_op(32'h1020, 32'h0000_2023, 32'h104, 32'hDEAD_BEEF, 1, 0, 0, 0, 0, 2, 1, 1, 32'h104, 4'hF, 32'hDEAD_BEEF);
    wait_idle();
    // LW x0: data returned but no register write
    rdata_cfg = 32'h1234_5678;
    run_op(32'h1024, 32'h0000_2003, 32'h200, 0, 1, 32'h1234_5678, 1, 0, 0, 3, 1, 0, 32'h200, 4'hF, 0);
    wait_idle();
    // LD on RV32 is an illegal funct3 and reported as misaligned
    run_op(32'h1028, 32'h0000_3583, 32'h100, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    wait_idle();
    // ADDI x0, BEQ, LUI x1: write-enable decode
    run_op(32'h102C, 32'h0000_0013, 32'h77, 0, 1, 32'h77, 1, 0, 0, 1, 0, 0, 0, 0, 0);
    wait_idle();
    run_op(32'h1030, 32'h0000_0663, 32'h1, 0, 1, 32'h1, 1, 0, 0, 1, 0, 0, 0, 0, 0);
    wait_idle();
    run_op(32'h1034, 32'h0000_00B7, 32'hABCD_E000, 0, 1, 32'hABCD_E000, 1, 1, 0, 1, 0, 0, 0, 0, 0);
    wait_idle();

    // LW x13 granted, flushed in RSP, rvalid three cycles after the flush
    gnt_wait = 0; rv_delay = 3; rdata_cfg = 32'hCAFE_F00D;
    run_op(32'h1038, 32'h0000_2683, 32'h300, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h300, 4'hF, 0);
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_ex_ready_rsp", ex_ready, 0);
    @(posedge clk); #1;
    flush = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("drain_ex_ready", ex_ready, 0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("drain_done_ex_ready", ex_ready, 1);
    @(posedge clk); #1;
    wait_idle();

    // Writeback stall for four cycles
    rv_delay = 0;
    wb_ready = 1'b0;
    run_op(32'h103C, 32'h0000_0713, 32'h5555, 0, 1, 32'h5555, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("stall_wb_valid", wb_valid, 1);
      chk("stall_wb_result", wb_result, 32'h5555);
      chk("stall_wb_rd", wb_rd, 14);
      chk("stall_ex_ready", ex_ready, 0);
      @(posedge clk); #1;
    end
    wb_ready = 1'b1;
    wait_idle();

    // Asynchronous reset while a request is waiting for grant
    gnt_wait = 10;
    run_op(32'h1040, 32'h0000_2783, 32'h400, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h400, 4'hF, 0);
    @(posedge clk); #1;
    chk("req_before_rst", dmem_req, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_dmem_req", dmem_req, 0);
    chk("async_rst_dmem_addr", dmem_addr, 0);
    chk("async_rst_wb_valid", wb_valid, 0);
    mem_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    gnt_wait = 0;
    @(posedge clk); #1;
    // Clean op after reset
    run_op(32'h1044, 32'h0000_0293, 32'h4321, 0, 1, 32'h4321, 1, 1, 0, 1, 0, 0, 0, 0, 0);
    wait_idle();

    chk("wb_q_empty", wb_q.size(), 0);
    chk("mem_q_empty", mem_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu
Overview:
Parametrised, handshaked load/store memory-access stage for the RV32I/RV64I core; sits between execute and writeback and drives a request/grant/response data-memory port that may insert wait states. Handles byte-lane alignment, sign/zero extension, misalignment detection and flush, and passes non-memory results through.
Parameters:
XLEN, 32, datapath width; legal values 32 or 64
ADDR_W, 32, data-memory address width
Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
flush  in  1  kill in-flight/pending op (pipeline redirect)
ex_valid  in  1  execute-stage op valid
ex_ready  out  1  stage can accept op
ex_pc  in  ADDR_W  op PC
ex_ir  in  32  op instruction word
ex_alu_out  in  XLEN  effective address or ALU result
ex_rs2  in  XLEN  store data
wb_valid  out  1  writeback record valid
wb_ready  in  1  writeback consumes record
wb_pc  out  ADDR_W  op PC
wb_ir  out  32  op instruction word
wb_result  out  XLEN  load data or passed-through ALU result
wb_rd  out  5  destination register (ir[11:7])
wb_we  out  1  register-file write enable
wb_exc  out  1  misaligned-access exception
dmem_req  out  1  memory request
dmem_we  out  1  1 = store
dmem_addr  out  ADDR_W  XLEN/8-aligned address
dmem_be  out  XLEN/8  byte enables
dmem_wdata  out  XLEN  lane-replicated store data
dmem_gnt  in  1  request accepted this cycle
dmem_rvalid  in  1  load data valid (earliest cycle after gnt)
dmem_rdata  in  XLEN  load data
Behaviour:
- Reset: state IDLE; wb_valid, wb_we, wb_exc, dmem_req, dmem_we = 0; all data outputs 0.
- FSM: IDLE, REQ, RSP, DRAIN. ex_ready = (state==IDLE) && (!wb_valid || wb_ready) && !flush. Accept = ex_valid && ex_ready; op fields captured on accept.
- Opcodes: LOAD 0000011, STORE 0100011; everything else non-memory. Legal funct3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU, plus 011 LD, 110 LWU when XLEN=64; stores 000/001/010, plus 011 SD when XLEN=64. Illegal funct3 for a memory op is treated as misaligned (wb_exc=1).
- Non-memory: wb record loaded in accept cycle (wb_valid next cycle, latency 1); wb_result=ex_alu_out; wb_we=1 for LUI/AUIPC/JAL/JALR/OP/OP-IMM when rd!=0, else 0.
- Misaligned (address offset not a multiple of access size): no dmem_req; wb_valid after 1 cycle, wb_exc=1, wb_we=0.
- Aligned memory op: IDLE -> REQ; dmem_req/we/addr/be/wdata stay stable until dmem_gnt. Store: on gnt, load wb record (wb_we=0), go IDLE. Load: on gnt -> RSP; on dmem_rvalid, wb_result = extend(rdata >> 8*offset), wb_we=(rd!=0), go IDLE. Minimum load latency 3 cycles accept->wb_valid; stores 2 cycles.
- dmem_be = size mask (1/3/F/FF) << offset; dmem_wdata = rs2 low byte/half/word replicated across all lanes; dmem_addr = address with low log2(XLEN/8) bits cleared.
- wb record held stable while wb_valid && !wb_ready.
- flush: clears wb_valid; in REQ drops dmem_req and returns to IDLE next cycle (request never granted); in RSP -> DRAIN, waits for dmem_rvalid, discards data, returns to IDLE. gnt and flush in the same cycle counts as granted (store is committed but not reported; load -> DRAIN).
- rvalid outside RSP/DRAIN is ignored.
Decomposition:
Package rv_lsu_pkg: opcode and funct3 constants, FSM state enum, size-mask function. Sub-module lsu_align (combinational): byte enables, store-data replication, load extraction and sign/zero extension.
Test Plan:
- Pass-through ADDI rd=5, alu_out=0x1234 -> wb_valid 1 cycle later, wb_result=0x1234, wb_we=1, no dmem_req.
- LB addr 0x103, rdata=0x80FFFFFF, gnt after 2 wait cycles -> dmem_addr=0x100, be=0x8, wb_result=0xFFFFFF80; LBU same -> 0x00000080.
- SH addr 0x102, rs2=0xABCD1234 -> be=0xC, wdata=0x12341234, wb_we=0, wb_valid cycle after gnt.
- LW addr 0x102 -> no dmem_req, wb_exc=1, wb_we=0.
- Load granted, flush in RSP, rvalid 3 cycles later -> no wb_valid, ex_ready low until cycle after rvalid.
- wb_ready low 4 cycles with wb_valid high -> wb record stable, ex_ready=0; async rst mid-REQ -> dmem_req=0 immediately.
